// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // The counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// Combinational 1-bit full-adder cell used by the serial adder datapath.
module serial_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  // Sum is the parity of the three inputs, carry is their majority.
  always_comb begin
    s_o  = a_i ^ b_i ^ c_i;
    co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial adder core: consumes one operand bit per clock LSB-first,
// keeps the carry in a register and shifts sum bits into a result register.
// Optional macro SERIAL_SUB_EN adds a 'sub' input selecting A-B (two's
// complement: B inverted, carry-in forced to 1, select latched at start).
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             a_bit,
  input  logic             b_bit,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             b_eff;
  logic             c_in_eff;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_shift;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef SERIAL_SUB_EN
  logic sub_q, sub_d;
  logic sub_eff;

  // Subtract select comes straight from the port on the start cycle and
  // from the latched copy for the remaining bits.
  always_comb begin
    sub_eff  = accept ? sub : sub_q;
    sub_d    = sub_eff;
    b_eff    = b_bit ^ sub_eff;
    c_in_eff = accept ? (sub | cin) : carry_q;
  end

  // Hold the subtract select for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end
`else
  // Add-only build: carry-in comes from cin at bit 0, else the carry register.
  always_comb begin
    b_eff    = b_bit;
    c_in_eff = accept ? cin : carry_q;
  end
`endif

  serial_full_adder u_fa (
    .a_i  (a_bit),
    .b_i  (b_eff),
    .c_i  (c_in_eff),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New sum bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
  if (WIDTH == 1) begin : g_shift_1
    assign sum_shift = fa_s;
  end else begin : g_shift_n
    assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
  end

  // Next-state and datapath update for the framing FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          sum_d   = sum_shift;
          carry_d = fa_co;
          cnt_d   = CNT_ONE;
          if (WIDTH == 1) begin
            cout_d  = fa_co;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_core.sv
// Self-checking bench for serial_adder_core: directed cases plus randomized
// operations compared against an arithmetic reference (A+B+cin, or A-B when
// SERIAL_SUB_EN is defined).
module tb_serial_adder_core;

  localparam int W = 8;
  localparam logic [W:0] ONE = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         a_bit;
  logic         b_bit;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .a_bit (a_bit),
    .b_bit (b_bit),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Runs one operation starting at the current negedge. Bits are presented
  // LSB-first, as the upstream rotate registers would. repulse_at re-asserts
  // start in that RUN cycle; abort_at asserts reset in that cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic sb,
                       input int repulse_at, input int abort_at,
                       output int done_cyc);
    logic [W:0] full;
    int st;
    if (sb) full = {1'b0, a} + {1'b0, ~b} + ONE;
    else    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    st = cyc;
    done_cyc = -1;
    for (int k = 0; k < W; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k == abort_at) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_sum", sum, 0);
          chk("rst_cout", cout, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          @(negedge clk);
          rst = 1'b0;
          start = 1'b0;
          return;
        end
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
      end
      a_bit = a[k];
      b_bit = b[k];
      start = (k == 0) || (k == repulse_at);
      cin   = (k == 0) ? c : 1'($urandom);
`ifdef SERIAL_SUB_EN
      sub   = (k == 0) ? sb : 1'($urandom);
`endif
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("sum", sum, full[W-1:0]);
    chk("cout", cout, full[W]);
    chk("latency", cyc - st, W);
    done_cyc = cyc;
    last_sum = full[W-1:0];
    last_cout = full[W];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      a_bit = 1'($urandom);
      b_bit = 1'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int d1, d2, prev;
    logic [W-1:0] ra, rb;
    logic rsb;
    bit chain;
    rst = 1'b1; start = 1'b0; cin = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    do_op(8'h5A, 8'h33, 1'b0, 1'b0, -1, -1, d1);
    idle(1);
    chk("idle_done", done, 0);
    idle(2);
    chk("hold_sum", sum, last_sum);
    chk("hold_cout", cout, last_cout);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, -1, d1);
    idle(2);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, -1, -1, d1);
    idle(1);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 3, -1, d1);
    idle(1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, -1, d1);
    idle(1);

    // Reset in the middle of an operation, then an immediate fresh start.
    do_op(8'hFF, 8'h00, 1'b0, 1'b0, -1, 4, d1);
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, -1, -1, d1);

    // Back-to-back: second start presented in the DONE cycle.
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, -1, -1, d2);
    chk("b2b_gap", d2 - d1, W);
    idle(1);

`ifdef SERIAL_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, -1, -1, d1);
    idle(1);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, -1, -1, d1);
    idle(1);
`endif

    prev = -100;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      rsb = 1'($urandom);
`else
      rsb = 1'b0;
`endif
      do_op(ra, rb, 1'($urandom), rsb,
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : -1,
            -1, d1);
      if (chain) chk("rand_b2b_gap", d1 - prev, W);
      prev = d1;
      chain = ($urandom_range(0, 1) == 1);
      if (!chain) idle(int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_core.md
Name: serial_adder_core

Overview:
- Downstream consumer of the 8-bit rotating operand registers in the bit-serial adder datapath.
- Each clock, takes the current LSB of operand A and operand B from two upstream rotate registers.
- Adds them with a registered carry and shifts each sum bit, LSB-first, into a result shift register.
- A small FSM with a bit counter frames one WIDTH-cycle addition per start pulse and flags completion.

Parameters:
- WIDTH, 8, operand/result width in bits; equals the upstream rotate-register width; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; marks the cycle in which a_bit/b_bit carry bit 0.
- cin  input  1  carry-in, sampled only in the start cycle.
- a_bit  input  1  current LSB of upstream operand-A rotate register.
- b_bit  input  1  current LSB of upstream operand-B rotate register.
- sum  output  WIDTH  result shift register; valid when done=1, held until the next accepted start.
- cout  output  1  final carry-out; valid with done.
- busy  output  1  high while an addition is in progress (state RUN).
- done  output  1  one-cycle pulse; sum/cout complete.

Behaviour:
- Single clock domain, clk.
- Reset is asynchronous and active-high on rst.
- While rst=1: state=IDLE, cnt=0, carry=0, sum=0, cout=0, busy=0, done=0.
- Full-adder cell (combinational): s = a_bit ^ b_bit ^ c_in_eff; co = majority(a_bit, b_bit, c_in_eff).
  - c_in_eff = cin when start is accepted, else the carry register.
- States:
  - IDLE: waiting for start.
  - RUN: consuming bits 1..WIDTH-1.
  - DONE: result valid for one cycle.
- Start acceptance: start is accepted only in IDLE or DONE. On the accepting edge:
  - Bit 0 is consumed: sum <= {s, sum[WIDTH-1:1]}, carry <= co, cnt <= 1.
  - If WIDTH>1, next state is RUN. If WIDTH=1, next state is DONE and cout <= co.
- RUN: each edge consumes bit cnt: sum <= {s, sum[WIDTH-1:1]}, carry <= co, cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: cout <= co, state <= DONE, cnt <= 0.
- DONE: done=1 and busy=0.
  - Next edge goes to IDLE, or directly into a new operation if start=1 (back-to-back, no bubble).
- Latency: done is high in the WIDTH-th cycle after the start cycle (start at cycle 0 -> done at cycle WIDTH).
  - Throughput: one addition per WIDTH cycles.
- busy and done are registered state decodes; they are never high together.
- start during RUN is ignored; the operation in progress is not disturbed.
- sum shows partial values during RUN. sum and cout hold their last values in IDLE until the next accepted start.
- Overflow: the carry beyond WIDTH appears only on cout; sum wraps modulo 2^WIDTH.
- Reset mid-operation aborts immediately. The upstream registers reload on the same rst, so the next start realigns at bit 0.
- Alignment contract: the upstream registers rotate every clock. The controller pulses start in the first clock after rst deasserts.

Optional Feature:
- SERIAL_SUB_EN: defined -> adds input port sub (1 bit, sampled with start).
  - When sub=1, b_bit is inverted for all WIDTH bits and c_in_eff at bit 0 is forced to 1 (cin ignored).
  - Result is A-B mod 2^WIDTH; cout=1 means no borrow.
  - The inversion select is latched at start.
- Undefined -> no sub port; add only.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - default WIDTH constant.
  - cnt width as $clog2(WIDTH+1).
- One natural sub-module: serial_full_adder (combinational 1-bit full adder cell), instantiated once.

Test Plan:
- A=8'h5A, B=8'h33, cin=0, start at cycle 0 -> done at cycle 8, sum=8'h8D, cout=0; busy high cycles 1-7.
- A=8'hFF, B=8'h01, cin=0 -> sum=8'h00, cout=1. Then A=8'h00, B=8'h00, cin=1 -> sum=8'h01, cout=0.
- Start re-pulsed at cycle 3 of A=8'h12+B=8'h34 -> ignored; done still at cycle 8, sum=8'h46.
- rst asserted at cycle 4 mid-operation -> sum=0, cout=0, busy=0, done=0 asynchronously. Fresh start afterwards: 8'h0F+8'h01 -> 8'h10.
- start held in the DONE cycle -> new operation begins with no idle cycle; second done exactly 8 cycles after the first.
- With SERIAL_SUB_EN defined: A=8'h10, B=8'h01, sub=1 -> sum=8'h0F, cout=1. A=8'h01, B=8'h02, sub=1 -> sum=8'hFF, cout=0.
